build_node_lists: RTL and testbench
===================================

Name: build_node_lists

Overview:
- Upstream stage of the supernode search. It walks the element table and builds one linked list per circuit node of incident-element entries in the nodeToElement RAM.
- It also builds the list heads in the nodeHeads RAM.
- On completion the supernode search can start from a valid nodeHeads/nodeToElement image, using num_nodes from this block.
- Each element produces two list entries, one per terminal. Capacity is therefore 16 elements / 32 entries.

Parameters:
- RAM_LAT, 2, read latency in clocks from address presentation to valid data (element and nodeHeads RAMs).
- MAX_ELEM, 16, maximum numElements accepted.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  level request; sampled in IDLE
- busy  out  1  high from first cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when lists are complete
- error  out  1  sticky until next start; numElements > MAX_ELEM or zero
- numElements  in  5  element count
- element_addr  out  4  element RAM read address
- element_out  in  44  element record: [43:39] node_a, [38:34] node_b, [33:32] type, [31:0] value
- nodeHeads_addr  out  5
- nodeHeads_data  out  64
- nodeHeads_wren  out  1
- nodeHeads_out  in  64
- nodeToElement_addr  out  5
- nodeToElement_data  out  64
- nodeToElement_wren  out  1
- num_nodes  out  5  highest node index seen; with ground 0, node count = num_nodes+1

Behaviour:
- Reset (resetn=0, async): all outputs 0, state IDLE, counters 0.
- Entry format written to nodeToElement:
  - [63] end-of-list, [62:58] next entry addr
  - [44] sign, [43:39] other node, [38:34] this node
  - [33:32] type, [31:0] value; other bits 0
- nodeHeads format:
  - [63] list built, [51:47] saved search addr (write 0), [46:42] head entry addr
  - [41:37] eqn index (0), [36:32] ref node (0), [31:0] voltage (0)
- Entry addresses: element i uses entry 2i (this=node_a, other=node_b, sign=0) and entry 2i+1 (this=node_b, other=node_a, sign=1).
- FSM states:
  - IDLE: on start=1:
    - if numElements==0 or >16, set error, pulse done, return to IDLE;
    - else clear error, busy=1, go to CLEAR.
  - CLEAR: write 64'h0 to nodeHeads[0..31], one per clock (32 cycles), then FETCH.
  - FETCH: drive element_addr=i; wait RAM_LAT cycles; latch record.
    - num_nodes <= max(num_nodes, node_a, node_b).
  - HEAD_RD: nodeHeads_addr=this node; wait RAM_LAT cycles.
  - LINK: build entry:
    - if nodeHeads_out[63]==0: [63]=1, next=0;
    - else [63]=0, next=nodeHeads_out[46:42].
    - Write nodeToElement[entry], wren=1 for exactly 1 cycle.
  - HEAD_WR: nodeHeads_data = nodeHeads_out with [63]=1, [46:42]=entry; wren=1 for exactly 1 cycle.
    - If the second terminal is not yet done, go to HEAD_RD for node_b; else NEXT.
  - NEXT: i+1; if i+1==numElements go to DONE, else FETCH.
  - DONE: done=1 one cycle, busy=0, go to IDLE.
- Write enables are never high while the corresponding address is changing in the same cycle.
- Lists are head-inserted: traversal order is reverse insertion order.
- Self-loop (node_a==node_b): both entries are linked into the same list. The second head read must see the first head write; the RAM is read-during-write old-data, so HEAD_RD begins at least one cycle after HEAD_WR.
- start is ignored while busy. resetn mid-operation aborts immediately; RAM contents are undefined and a new start is required.
- Latency: 32 + numElements*(2*RAM_LAT+... per-element constant K) + 2 cycles. K is fixed by implementation and documented in the header.

Decomposition:
- Shared package (circuit_pkg): bit-field constants for the nodeHeads layout (BUILT=63, SAVED_HI/LO, HEAD_HI/LO, EQN_HI/LO, REF_HI/LO), the nodeToElement layout (EOL=63, NEXT, SIGN=44, OTHER, THIS, TYPE, VALUE), the element record layout, and type codes (VSRC=0, RES=1, ISRC=2).
- Natural sub-module: ram_wait_counter, a reloadable RAM_LAT down-counter that issues a data_valid pulse. It is reused by the FSM for all reads.

Test Plan:
- Single resistor element {a=1,b=0,type=1,val=32'h3F800000}, numElements=1 ->
  - nodeToElement[0] = EOL=1, this=1, other=0, sign=0;
  - nodeToElement[1] = EOL=1, this=0, other=1, sign=1;
  - nodeHeads[1].head=0, nodeHeads[0].head=1, both built=1; num_nodes=1; done pulses once.
- Three elements all on node 2 (2-1, 2-3, 2-0) -> nodeHeads[2].head=4; chain 4->2->0 with entry 0 EOL=1; all other nodes have single-entry lists.
- Self-loop element a=b=5 -> nodeHeads[5].head=1; entry1.next=0, EOL=0; entry0 EOL=1.
- numElements=0 and numElements=17 -> error=1, done pulse, no RAM writes asserted.
- resetn low for 1 cycle midway through LINK -> busy=0, all wrens 0 asynchronously. A fresh start then rebuilds the correct lists, all untouched nodes have built=0, and the checker compares the full 32-entry images.

Source files
------------

// File: rtl/circuit_pkg.sv
// Shared field layouts for the element table, nodeHeads and nodeToElement RAMs,
// plus the list-builder state encoding and small word-assembly helpers.
package circuit_pkg;

  localparam int BUILT    = 63;
  localparam int SAVED_HI = 51;
  localparam int SAVED_LO = 47;
  localparam int HEAD_HI  = 46;
  localparam int HEAD_LO  = 42;
  localparam int EQN_HI   = 41;
  localparam int EQN_LO   = 37;
  localparam int REF_HI   = 36;
  localparam int REF_LO   = 32;

  localparam int EOL      = 63;
  localparam int NEXT_HI  = 62;
  localparam int NEXT_LO  = 58;
  localparam int SIGN     = 44;
  localparam int OTHER_HI = 43;
  localparam int OTHER_LO = 39;
  localparam int THIS_HI  = 38;
  localparam int THIS_LO  = 34;
  localparam int TYPE_HI  = 33;
  localparam int TYPE_LO  = 32;
  localparam int VALUE_HI = 31;
  localparam int VALUE_LO = 0;

  localparam int EL_A_HI    = 43;
  localparam int EL_A_LO    = 39;
  localparam int EL_B_HI    = 38;
  localparam int EL_B_LO    = 34;
  localparam int EL_TYPE_HI = 33;
  localparam int EL_TYPE_LO = 32;
  localparam int EL_VAL_HI  = 31;
  localparam int EL_VAL_LO  = 0;

  typedef enum logic [1:0] {VSRC = 2'd0, RES = 2'd1, ISRC = 2'd2} elem_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_HEAD_RD, S_LINK, S_HEAD_WR, S_NEXT, S_DONE
  } state_e;

  function automatic logic [4:0] max3(input logic [4:0] x, input logic [4:0] y,
                                      input logic [4:0] z);
    logic [4:0] m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  function automatic logic [63:0] entry_word(input logic eol, input logic [4:0] nxt,
                                             input logic sign, input logic [4:0] other,
                                             input logic [4:0] this_node,
                                             input logic [1:0] etype,
                                             input logic [31:0] value);
    logic [63:0] w;
    w = '0;
    w[EOL] = eol;
    w[NEXT_HI:NEXT_LO] = nxt;
    w[SIGN] = sign;
    w[OTHER_HI:OTHER_LO] = other;
    w[THIS_HI:THIS_LO] = this_node;
    w[TYPE_HI:TYPE_LO] = etype;
    w[VALUE_HI:VALUE_LO] = value;
    return w;
  endfunction

  // The search-side fields (eqn index, ref node, voltage) are carried through untouched.
  function automatic logic [63:0] head_word(input logic [63:0] old, input logic [4:0] entry);
    logic [63:0] w;
    w = old;
    w[BUILT] = 1'b1;
    w[SAVED_HI:SAVED_LO] = '0;
    w[HEAD_HI:HEAD_LO] = entry;
    return w;
  endfunction

endpackage

// File: rtl/build_node_lists_ram_wait_counter.sv
// Reloadable RAM_LAT down-counter: load in the cycle the read address is first
// presented, data_valid is high in the cycle the RAM data is usable.
module ram_wait_counter #(
  parameter int RAM_LAT = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  output logic data_valid
);

  localparam int CW = $clog2(RAM_LAT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt <= '0;
    else if (load)
      cnt <= CW'(RAM_LAT);
    else if (cnt != '0)
      cnt <= cnt - CW'(1);
  end

  assign data_valid = (cnt == CW'(1));

endmodule

// File: rtl/build_node_lists.sv
// Builds one head-inserted list of incident-element entries per circuit node.
// Latency: 32 + numElements*(2*RAM_LAT + K) + 2 cycles with K = RAM_LAT + 8 (10 at RAM_LAT=2).
module build_node_lists
  import circuit_pkg::*;
#(
  parameter int RAM_LAT  = 2,
  parameter int MAX_ELEM = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [4:0]  numElements,
  output logic [3:0]  element_addr,
  input  logic [43:0] element_out,
  output logic [4:0]  nodeHeads_addr,
  output logic [63:0] nodeHeads_data,
  output logic        nodeHeads_wren,
  input  logic [63:0] nodeHeads_out,
  output logic [4:0]  nodeToElement_addr,
  output logic [63:0] nodeToElement_data,
  output logic        nodeToElement_wren,
  output logic [4:0]  num_nodes
);

  localparam logic [5:0] MAX_E = 6'(MAX_ELEM);

  state_e      state, state_nx;
  logic [3:0]  idx;
  logic [4:0]  clr_cnt;
  logic [4:0]  n_q;
  logic        term;
  logic        armed;
  logic [4:0]  node_a, node_b;
  elem_type_e  etype;
  logic [31:0] evalue;
  logic [63:0] head_q;
  logic        load, data_valid;
  logic        bad_count;
  logic        last_elem;
  logic [4:0]  this_node, other_node, entry;

  ram_wait_counter #(.RAM_LAT(RAM_LAT)) u_wait (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .data_valid (data_valid)
  );

  assign bad_count  = (numElements == 5'd0) || ({1'b0, numElements} > MAX_E);
  assign last_elem  = (({1'b0, idx} + 5'd1) == n_q);
  assign this_node  = term ? node_b : node_a;
  assign other_node = term ? node_a : node_b;
  assign entry      = {idx, term};

  assign element_addr       = idx;
  assign nodeToElement_addr = entry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx           = state;
    load               = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    nodeHeads_addr     = '0;
    nodeHeads_data     = '0;
    nodeHeads_wren     = 1'b0;
    nodeToElement_data = '0;
    nodeToElement_wren = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = bad_count ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        busy           = 1'b1;
        nodeHeads_addr = clr_cnt;
        nodeHeads_wren = 1'b1;
        if (clr_cnt == 5'd31)
          state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        load = !armed;
        if (armed && data_valid)
          state_nx = S_HEAD_RD;
      end
      S_HEAD_RD: begin
        busy           = 1'b1;
        nodeHeads_addr = this_node;
        load           = !armed;
        if (armed && data_valid)
          state_nx = S_LINK;
      end
      S_LINK: begin
        busy               = 1'b1;
        nodeHeads_addr     = this_node;
        nodeToElement_data = entry_word(!head_q[BUILT],
                                        head_q[BUILT] ? head_q[HEAD_HI:HEAD_LO] : 5'd0,
                                        term, other_node, this_node, etype, evalue);
        nodeToElement_wren = 1'b1;
        state_nx           = S_HEAD_WR;
      end
      S_HEAD_WR: begin
        busy           = 1'b1;
        nodeHeads_addr = this_node;
        nodeHeads_data = head_word(head_q, entry);
        nodeHeads_wren = 1'b1;
        // Re-reading after this write lets a self-loop see its own first entry.
        state_nx       = term ? S_NEXT : S_HEAD_RD;
      end
      S_NEXT: begin
        busy     = 1'b1;
        state_nx = last_elem ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx       <= '0;
      clr_cnt   <= '0;
      n_q       <= '0;
      term      <= 1'b0;
      armed     <= 1'b0;
      node_a    <= '0;
      node_b    <= '0;
      etype     <= VSRC;
      evalue    <= '0;
      head_q    <= '0;
      num_nodes <= '0;
      error     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_q     <= numElements;
            error   <= bad_count;
            idx     <= '0;
            clr_cnt <= '0;
            term    <= 1'b0;
            armed   <= 1'b0;
            if (!bad_count)
              num_nodes <= '0;
          end
        end
        S_CLEAR: clr_cnt <= clr_cnt + 5'd1;
        S_FETCH: begin
          if (!armed)
            armed <= 1'b1;
          else if (data_valid) begin
            armed     <= 1'b0;
            term      <= 1'b0;
            node_a    <= element_out[EL_A_HI:EL_A_LO];
            node_b    <= element_out[EL_B_HI:EL_B_LO];
            etype     <= elem_type_e'(element_out[EL_TYPE_HI:EL_TYPE_LO]);
            evalue    <= element_out[EL_VAL_HI:EL_VAL_LO];
            num_nodes <= max3(num_nodes, element_out[EL_A_HI:EL_A_LO],
                              element_out[EL_B_HI:EL_B_LO]);
          end
        end
        S_HEAD_RD: begin
          if (!armed)
            armed <= 1'b1;
          else if (data_valid) begin
            armed  <= 1'b0;
            head_q <= nodeHeads_out;
          end
        end
        S_HEAD_WR: if (!term) term <= 1'b1;
        S_NEXT: if (!last_elem) idx <= idx + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_build_node_lists.sv
// Bench for build_node_lists: latency-modelled RAMs, fixed vectors, random element
// tables checked against a per-node list model, and a reset during LINK.
module tb_build_node_lists;

  localparam int L = 2;
  localparam logic [63:0] SENT = 64'hA5A5_5A5A_C3C3_3C3C;

  typedef struct packed {
    logic [4:0]        n;
    logic [15:0][43:0] els;
    logic              exp_err;
    logic              has_chk;
    logic [4:0]        exp_nn;
    logic [4:0]        chk_node;
    logic [4:0]        chk_head;
    logic [4:0]        chk_entry;
    logic [63:0]       chk_word;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  numElements = '0;
  logic        busy, done, error;
  logic [3:0]  element_addr;
  logic [43:0] element_out;
  logic [4:0]  nodeHeads_addr, nodeToElement_addr, num_nodes;
  logic [63:0] nodeHeads_data, nodeHeads_out, nodeToElement_data;
  logic        nodeHeads_wren, nodeToElement_wren;

  always #5 clk = ~clk;

  build_node_lists #(.RAM_LAT(L), .MAX_ELEM(16)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .numElements        (numElements),
    .element_addr       (element_addr),
    .element_out        (element_out),
    .nodeHeads_addr     (nodeHeads_addr),
    .nodeHeads_data     (nodeHeads_data),
    .nodeHeads_wren     (nodeHeads_wren),
    .nodeHeads_out      (nodeHeads_out),
    .nodeToElement_addr (nodeToElement_addr),
    .nodeToElement_data (nodeToElement_data),
    .nodeToElement_wren (nodeToElement_wren),
    .num_nodes          (num_nodes)
  );

  logic [43:0] elem_mem [16];
  logic [63:0] nh_mem [32];
  logic [63:0] n2e_mem [32];
  logic [63:0] pre_nh [32];
  logic [43:0] el_pipe [L];
  logic [63:0] nh_pipe [L];
  logic        preload = 1'b0;
  int          wr_cnt = 0;

  assign element_out   = el_pipe[L-1];
  assign nodeHeads_out = nh_pipe[L-1];

  // Registered-read RAMs with old-data read-during-write.
  always @(posedge clk) begin
    el_pipe[0] <= elem_mem[element_addr];
    nh_pipe[0] <= nh_mem[nodeHeads_addr];
    for (int k = 1; k < L; k++) begin
      el_pipe[k] <= el_pipe[k-1];
      nh_pipe[k] <= nh_pipe[k-1];
    end
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        nh_mem[i]  <= pre_nh[i];
        n2e_mem[i] <= SENT;
      end
    end else begin
      if (nodeHeads_wren)     nh_mem[nodeHeads_addr]      <= nodeHeads_data;
      if (nodeToElement_wren) n2e_mem[nodeToElement_addr] <= nodeToElement_data;
    end
    if (nodeHeads_wren || nodeToElement_wren) wr_cnt <= wr_cnt + 1;
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [43:0] mk(input logic [4:0] a, input logic [4:0] b,
                                     input logic [1:0] t, input logic [31:0] v);
    return {a, b, t, v};
  endfunction

  logic [63:0] exp_nh [32];
  logic [63:0] exp_n2e [32];
  logic [4:0]  exp_nn;
  int          lists [32][$];

  // Each node's list holds its entries in insertion order; the head is the newest,
  // each entry points at the one inserted before it, the oldest carries end-of-list.
  task automatic model(input logic [4:0] n, input logic [15:0][43:0] els);
    for (int i = 0; i < 32; i++) begin
      exp_nh[i]  = '0;
      exp_n2e[i] = SENT;
      lists[i].delete();
    end
    exp_nn = '0;
    for (int e = 0; e < int'(n); e++) begin
      logic [4:0] ends [2];
      ends[0] = els[e][43:39];
      ends[1] = els[e][38:34];
      for (int t = 0; t < 2; t++) begin
        int me, ot, ent;
        logic [63:0] w;
        me  = int'(ends[t]);
        ot  = int'(ends[1-t]);
        ent = 2 * e + t;
        if (ends[t] > exp_nn) exp_nn = ends[t];
        w = '0;
        w[44] = (t == 1);
        w[43:39] = 5'(ot);
        w[38:34] = 5'(me);
        w[33:0] = els[e][33:0];
        if (lists[me].size() == 0) w[63] = 1'b1;
        else w[62:58] = 5'(lists[me][lists[me].size()-1]);
        exp_n2e[ent] = w;
        lists[me].push_back(ent);
      end
    end
    for (int i = 0; i < 32; i++)
      if (lists[i].size() > 0)
        exp_nh[i] = {1'b1, 63'd0} | (64'(lists[i][lists[i].size()-1]) << 42);
  endtask

  task automatic load_case(input vec_t v);
    for (int i = 0; i < 16; i++) elem_mem[i] = v.els[i];
    for (int i = 0; i < 32; i++) pre_nh[i] = {$urandom, $urandom};
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input bit poke, input string tag);
    int cyc, dcount, w0;
    bit seen;
    load_case(v);
    model(v.n, v.els);
    w0 = wr_cnt;
    numElements = v.n;
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 40) begin start = 1'b1; numElements = 5'd0; end
      if (poke && cyc == 41) begin start = 1'b0; numElements = v.n; end
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    dcount = seen ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check({tag, "_done_pulses"}, dcount, 1);
    check({tag, "_error"}, error, v.exp_err);
    check({tag, "_busy_after"}, busy, 1'b0);
    if (v.exp_err) begin
      check({tag, "_writes"}, wr_cnt - w0, 0);
    end else begin
      check({tag, "_latency"}, cyc + 1, 32 + int'(v.n) * (3 * L + 8) + 2);
      check({tag, "_num_nodes"}, num_nodes, exp_nn);
      for (int i = 0; i < 32; i++) begin
        check($sformatf("%s_nh[%0d]", tag, i), nh_mem[i], exp_nh[i]);
        check($sformatf("%s_n2e[%0d]", tag, i), n2e_mem[i], exp_n2e[i]);
      end
      if (v.has_chk) begin
        check({tag, "_nn_const"}, num_nodes, v.exp_nn);
        check({tag, "_head_const"}, nh_mem[v.chk_node][46:42], v.chk_head);
        check({tag, "_built_const"}, nh_mem[v.chk_node][63], 1'b1);
        check({tag, "_entry_const"}, n2e_mem[v.chk_entry], v.chk_word);
      end
    end
  endtask

  vec_t vecs [6];

  initial begin
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    vecs[0].n = 5'd1;
    vecs[0].els[0] = mk(5'd1, 5'd0, 2'd1, 32'h3F80_0000);
    vecs[0].has_chk = 1'b1;
    vecs[0].exp_nn = 5'd1;   vecs[0].chk_node = 5'd0; vecs[0].chk_head = 5'd1;
    vecs[0].chk_entry = 5'd1; vecs[0].chk_word = 64'h8000_1081_3F80_0000;

    vecs[1].n = 5'd3;
    vecs[1].els[0] = mk(5'd2, 5'd1, 2'd1, 32'h11);
    vecs[1].els[1] = mk(5'd2, 5'd3, 2'd1, 32'h22);
    vecs[1].els[2] = mk(5'd2, 5'd0, 2'd1, 32'h33);
    vecs[1].has_chk = 1'b1;
    vecs[1].exp_nn = 5'd3;   vecs[1].chk_node = 5'd2; vecs[1].chk_head = 5'd4;
    vecs[1].chk_entry = 5'd4; vecs[1].chk_word = 64'h0800_0009_0000_0033;

    vecs[2].n = 5'd1;
    vecs[2].els[0] = mk(5'd5, 5'd5, 2'd1, 32'h10);
    vecs[2].has_chk = 1'b1;
    vecs[2].exp_nn = 5'd5;   vecs[2].chk_node = 5'd5; vecs[2].chk_head = 5'd1;
    vecs[2].chk_entry = 5'd1; vecs[2].chk_word = 64'h0000_1295_0000_0010;

    vecs[3].n = 5'd0;  vecs[3].exp_err = 1'b1;
    vecs[4].n = 5'd17; vecs[4].exp_err = 1'b1;
    vecs[4].els[0] = mk(5'd3, 5'd4, 2'd0, 32'h1);

    vecs[5].n = 5'd16;
    for (int i = 0; i < 16; i++) vecs[5].els[i] = mk(5'(i), 5'(31 - i), 2'd2, 32'(i));
    vecs[5].has_chk = 1'b1;
    vecs[5].exp_nn = 5'd31;  vecs[5].chk_node = 5'd31; vecs[5].chk_head = 5'd1;
    vecs[5].chk_entry = 5'd1; vecs[5].chk_word = 64'h8000_107E_0000_0000;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_num_nodes", num_nodes, 5'd0);
    check("rst_nh_wren", nodeHeads_wren, 1'b0);
    check("rst_n2e_wren", nodeToElement_wren, 1'b0);
    check("rst_nh_addr", nodeHeads_addr, 5'd0);
    check("rst_el_addr", element_addr, 4'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_case(vecs[k], 1'b0, $sformatf("vec%0d", k));

    for (int r = 0; r < 6; r++) begin
      vec_t rv;
      rv = '0;
      rv.n = (r == 0) ? 5'd16 : 5'($urandom_range(1, 16));
      for (int i = 0; i < 16; i++)
        rv.els[i] = mk(5'($urandom_range(0, (r < 3) ? 7 : 31)),
                       5'($urandom_range(0, (r < 3) ? 7 : 31)),
                       2'($urandom_range(0, 2)), $urandom);
      run_case(rv, (r == 1), $sformatf("rnd%0d", r));
    end

    begin
      int cyc;
      bit found;
      load_case(vecs[1]);
      numElements = vecs[1].n;
      start = 1'b1;
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 500) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) start = 1'b0;
        if (nodeToElement_wren) found = 1'b1;
      end
      check("link_reached", found, 1'b1);
      resetn = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_nh_wren", nodeHeads_wren, 1'b0);
      check("abort_n2e_wren", nodeToElement_wren, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_num_nodes", num_nodes, 5'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      run_case(vecs[5], 1'b1, "post_reset");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
